bus_demux_1x4: RTL and testbench

BUS_DEMUX_1X4 -- requirements
Module: bus_demux_1x4

---
 rtl/bus_pkg.sv | 14 +
 rtl/bus_demux_1x4.sv | 175 +++++++++++++++++
 tb/tb_bus_demux_1x4.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the 1-to-4 bus demultiplexer: FSM state encoding
// and the default response-timeout constant.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/bus_demux_1x4.sv
// 1-to-4 request demultiplexer with one outstanding transaction.
// Optional response timeout enabled by defining BUS_DEMUX_TIMEOUT_EN.
//
// Handshake: a request transfers on a rising edge where valid and ready are
// both 1; valid holds with a stable payload until then. rsp_valid is a
// single-cycle pulse and the initiator cannot stall it.
module bus_demux_1x4
  import bus_pkg::*;
#(
  parameter int N       = 32,
  parameter int SEL_HI  = 31,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic           req_we,
  input  logic [N-1:0]   req_addr,
  input  logic [N-1:0]   req_wdata,
  output logic           rsp_valid,
  output logic [N-1:0]   rsp_rdata,
  output logic           rsp_err,
  output logic [3:0]     t_valid,
  input  logic [3:0]     t_ready,
  output logic           t_we,
  output logic [N-1:0]   t_addr,
  output logic [N-1:0]   t_wdata,
  input  logic [3:0]     t_rsp_valid,
  input  logic [4*N-1:0] t_rsp_rdata,
  output logic [1:0]     dbg_state
);

  if (TIMEOUT < 1 || SEL_HI >= N || SEL_HI < 1) begin : g_bad_cfg
    $error("bus_demux_1x4: invalid TIMEOUT/SEL_HI/N combination");
  end

  state_e     state;
  logic [1:0] sel;

  assign req_ready = (state == IDLE);
  assign dbg_state = state;

`ifdef BUS_DEMUX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tmo_cnt;
  logic          tmo_hit;

  // Fires on the last permitted REQ/WAIT cycle; a real response that same
  // cycle still wins.
  assign tmo_hit = (tmo_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= 2'd0;
      t_valid   <= 4'b0000;
      t_we      <= 1'b0;
      t_addr    <= '0;
      t_wdata   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            sel     <= req_addr[SEL_HI -: 2];
            t_valid <= 4'b0001 << req_addr[SEL_HI -: 2];
            t_we    <= req_we;
            t_addr  <= req_addr;
            t_wdata <= req_wdata;
            tmo_cnt <= '0;
            state   <= REQ;
          end
        end
        REQ: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (t_ready[sel] && t_rsp_valid[sel]) begin
            t_valid   <= 4'b0000;
            rsp_rdata <= t_rsp_rdata[sel*N +: N];
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (tmo_hit) begin
            t_valid   <= 4'b0000;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (t_ready[sel]) begin
            t_valid <= 4'b0000;
            state   <= WAIT;
          end
        end
        WAIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (t_rsp_valid[sel]) begin
            rsp_rdata <= t_rsp_rdata[sel*N +: N];
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (tmo_hit) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          rsp_valid <= 1'b0;
          tmo_cnt   <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign rsp_err = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= 2'd0;
      t_valid   <= 4'b0000;
      t_we      <= 1'b0;
      t_addr    <= '0;
      t_wdata   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            sel     <= req_addr[SEL_HI -: 2];
            t_valid <= 4'b0001 << req_addr[SEL_HI -: 2];
            t_we    <= req_we;
            t_addr  <= req_addr;
            t_wdata <= req_wdata;
            state   <= REQ;
          end
        end
        REQ: begin
          if (t_ready[sel]) begin
            t_valid <= 4'b0000;
            // Target may accept and answer in the same cycle.
            if (t_rsp_valid[sel]) begin
              rsp_rdata <= t_rsp_rdata[sel*N +: N];
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (t_rsp_valid[sel]) begin
            rsp_rdata <= t_rsp_rdata[sel*N +: N];
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_bus_demux_1x4.sv
// Directed-vector bench for bus_demux_1x4 with a response scoreboard.
module tb_bus_demux_1x4;
  import bus_pkg::*;

  localparam int N = 32;

  logic           clk;
  logic           rst_n;
  logic           req_valid;
  logic           req_ready;
  logic           req_we;
  logic [N-1:0]   req_addr;
  logic [N-1:0]   req_wdata;
  logic           rsp_valid;
  logic [N-1:0]   rsp_rdata;
  logic           rsp_err;
  logic [3:0]     t_valid;
  logic [3:0]     t_ready;
  logic           t_we;
  logic [N-1:0]   t_addr;
  logic [N-1:0]   t_wdata;
  logic [3:0]     t_rsp_valid;
  logic [4*N-1:0] t_rsp_rdata;
  logic [1:0]     dbg_state;

  int checks;
  int errors;

  logic [N-1:0] exp_q[$];
  logic         exp_err_q[$];

  bus_demux_1x4 #(.N(N), .SEL_HI(31), .TIMEOUT(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .t_valid     (t_valid),
    .t_ready     (t_ready),
    .t_we        (t_we),
    .t_addr      (t_addr),
    .t_wdata     (t_wdata),
    .t_rsp_valid (t_rsp_valid),
    .t_rsp_rdata (t_rsp_rdata),
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Drives one request; returns at the first negedge with the DUT in REQ.
  task automatic issue(input logic we, input logic [N-1:0] addr, input logic [N-1:0] wdata);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    tick();
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic target_rsp(input int k, input logic [N-1:0] data);
    t_rsp_valid       = 4'b0001 << k;
    t_rsp_rdata       = '0;
    t_rsp_rdata[k*N +: N] = data;
  endtask

  task automatic clear_target();
    t_ready     = 4'b0000;
    t_rsp_valid = 4'b0000;
    t_rsp_rdata = '0;
  endtask

  task automatic expect_rsp(input logic [N-1:0] data, input logic err);
    exp_q.push_back(data);
    exp_err_q.push_back(err);
  endtask

  // Monitor: every rsp_valid pulse must match the oldest expected response.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rdata 0x%0h err %0b with nothing expected",
                   rsp_rdata, rsp_err);
        end else begin
          chk("rsp_rdata", rsp_rdata, exp_q.pop_front());
          chk("rsp_err", rsp_err, exp_err_q.pop_front());
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    clear_target();

    // Reset values
    #2;
    chk("rst_t_valid", t_valid, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_state", dbg_state, IDLE);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Read sel=1, target accepts on first REQ cycle, answers two cycles later
    issue(1'b0, 32'h4000_0010, 32'h0);
    chk("t1_t_valid", t_valid, 4'b0010);
    chk("t1_t_addr", t_addr, 32'h4000_0010);
    chk("t1_t_we", t_we, 0);
    chk("t1_req_ready", req_ready, 0);
    t_ready = 4'b0010;
    tick();
    t_ready = 4'b0000;
    chk("t1_t_valid_drop", t_valid, 4'b0000);
    chk("t1_state_wait", dbg_state, WAIT);
    tick();
    expect_rsp(32'h1234_5678, 1'b0);
    target_rsp(1, 32'h1234_5678);
    tick();
    clear_target();
    chk("t1_rsp_valid", rsp_valid, 1);
    tick();
    chk("t1_rsp_one_cycle", rsp_valid, 0);
    chk("t1_rdata_hold", rsp_rdata, 32'h1234_5678);
    chk("t1_back_idle", req_ready, 1);

    // Write sel=3 with t_ready low for 5 cycles
    issue(1'b1, 32'hC000_0000, 32'hA5A5_A5A5);
    for (int i = 0; i < 6; i++) begin
      chk("t2_t_valid_held", t_valid, 4'b1000);
      chk("t2_t_wdata", t_wdata, 32'hA5A5_A5A5);
      chk("t2_t_we", t_we, 1);
      chk("t2_req_ready", req_ready, 0);
      if (i == 5) t_ready = 4'b1000;
      tick();
    end
    t_ready = 4'b0000;
    chk("t2_t_valid_drop", t_valid, 4'b0000);
    expect_rsp(32'hDEAD_BEEF, 1'b0);
    target_rsp(3, 32'hDEAD_BEEF);
    tick();
    clear_target();
    tick();

    // Read sel=2 with spurious traffic from target 0
    issue(1'b0, 32'h8000_0004, 32'h0);
    t_ready = 4'b0001;
    tick();
    chk("t3_ignore_ready0", t_valid, 4'b0100);
    t_ready = 4'b0100;
    tick();
    t_ready = 4'b0000;
    target_rsp(0, 32'hBAD0_BAD0);
    tick();
    chk("t3_ignore_rsp0", dbg_state, WAIT);
    chk("t3_no_rsp", rsp_valid, 0);
    expect_rsp(32'h0000_CAFE, 1'b0);
    target_rsp(2, 32'h0000_CAFE);
    tick();
    clear_target();
    chk("t3_rsp_valid", rsp_valid, 1);
    tick();

    // Same-cycle ready and response: minimum latency
    issue(1'b0, 32'h0000_0020, 32'h0);
    t_ready = 4'b0001;
    expect_rsp(32'h0F0F_0F0F, 1'b0);
    target_rsp(0, 32'h0F0F_0F0F);
    tick();
    clear_target();
    chk("t4_min_latency", rsp_valid, 1);
    tick();

`ifdef BUS_DEMUX_TIMEOUT_EN
    // Unresponsive target with TIMEOUT=8
    issue(1'b0, 32'h4000_0000, 32'h0);
    for (int i = 0; i < 8; i++) begin
      chk("t5_t_valid_wait", t_valid, 4'b0010);
      if (i == 7) expect_rsp(32'h0, 1'b1);
      tick();
    end
    chk("t5_tmo_rsp", rsp_valid, 1);
    chk("t5_tmo_t_valid", t_valid, 4'b0000);
    target_rsp(1, 32'h7777_7777);
    tick();
    tick();
    clear_target();
    chk("t5_late_ignored", dbg_state, IDLE);
    tick();
`endif

    // Reset while in WAIT
    issue(1'b0, 32'h4000_0000, 32'h0);
    t_ready = 4'b0010;
    tick();
    t_ready = 4'b0000;
    chk("t6_in_wait", dbg_state, WAIT);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_state", dbg_state, IDLE);
    chk("t6_rst_t_valid", t_valid, 0);
    chk("t6_rst_rsp_valid", rsp_valid, 0);
    chk("t6_rst_rsp_rdata", rsp_rdata, 0);
    chk("t6_rst_rsp_err", rsp_err, 0);
    chk("t6_rst_t_addr", t_addr, 0);
    chk("t6_rst_t_we", t_we, 0);
    tick();
    rst_n = 1'b1;
    chk("t6_req_ready", req_ready, 1);
    target_rsp(1, 32'h5555_AAAA);
    tick();
    tick();
    clear_target();
    chk("t6_no_rsp_state", dbg_state, IDLE);
    tick();
    tick();

    chk("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net against a stalled run
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $finish;
  end

endmodule
